hi_lo_unit: RTL and testbench
=============================

# hi_lo_unit

- Holds the architectural HI/LO register pair and executes a multi-cycle iterative divide (DIV/DIVU).
- Sits directly downstream of the ALU:
  - Captures the 64-bit result of the ALU's mult/multu/madd/msub operations.
  - Its HI/LO outputs feed back into the ALU's HI and LO operand inputs.
- Also handles mthi/mtlo writes.
- Raises a stall to the pipeline while a divide is in flight.

## Interface
Parameters:
- DIV_STEPS, 32, number of quotient bits produced, one per cycle (fixed at 32 for this datapath).

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- OpValid  in  1  an operation is presented this cycle.
- Op  in  3  operation code:
  - 000 NOP
  - 001 WRITE
  - 010 MTHI
  - 011 MTLO
  - 100 DIV
  - 101 DIVU
  - 110/111 treated as NOP
- ALUResult  in  32  low word from ALU, written to LO on WRITE.
- ALUResultHI  in  32  high word from ALU, written to HI on WRITE.
- RsData  in  32  source for MTHI/MTLO; dividend for DIV/DIVU.
- RtData  in  32  divisor for DIV/DIVU.
- HiLoRead  in  1  a downstream consumer (mfhi/mflo/madd/msub) reads HI/LO this cycle.
- HI  out  32  current HI register.
- LO  out  32  current LO register.
- Busy  out  1  divide in progress.
- Stall  out  1  pipeline must hold the current instruction.
- DivDone  out  1  one-cycle pulse; HI/LO now hold the divide result.

## Operation
- Reset (Reset=0, asynchronous, any time including mid-divide):
  - HI=0, LO=0, Busy=0, DivDone=0.
  - Divider state is cleared and any in-flight divide is abandoned.
- An op is accepted at a rising edge when OpValid=1 and Busy=0:
  - WRITE: HI<=ALUResultHI, LO<=ALUResult in the same edge.
  - MTHI: HI<=RsData; LO unchanged.
  - MTLO: LO<=RsData; HI unchanged.
  - DIV/DIVU: latch operands, Busy<=1. HI/LO keep their old values until completion.
- Divider:
  - Radix-2 restoring on 32-bit magnitudes with a 33-bit partial-remainder subtractor.
  - States: IDLE, RUN (step counter 0..31).
  - IDLE -> RUN on accept.
  - RUN performs one shift/subtract per cycle.
  - RUN -> IDLE after step 31, writing the final result.
- DIVU: operands are taken as unsigned.
- DIV sign rules:
  - Operands are taken as absolute values.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Results are truncating, consistent with the ALU's two's-complement arithmetic.
- Divide by zero (DIV or DIVU):
  - LO=32'hFFFFFFFF, HI=dividend (original RsData, unmodified).
  - Still takes the full latency.
- DIV overflow, 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- Stall = Busy & (OpValid | HiLoRead), combinational.
  - Any op presented while Busy is ignored; upstream holds it until Busy drops.
- OpValid=0 or an unused opcode: no state change.

## Timing
- WRITE/MTHI/MTLO: HI/LO visible on outputs one cycle after the accepting edge (latency 1, no stall).
- DIV/DIVU accepted at edge E0:
  - Busy=1 from after E0 until edge E32.
  - Iteration steps occur at edges E1..E32.
  - At E32, HI<=remainder and LO<=quotient (sign-corrected), Busy<=0, DivDone<=1.
  - DivDone clears at E33.
- Busy is high for exactly 32 cycles; Stall is asserted in the same cycle its conditions are true.
- An op presented in the cycle after E32 (Busy=0) is accepted at E33 and sees the new HI/LO.
- Back-to-back divides: the second is accepted at E33 at the earliest, so a 33-cycle throughput.
- Consumer hazard: the ALU reads HI/LO combinationally. When HiLoRead=1 and Busy=1, the result is held off via Stall until HI/LO hold the final divide result.

## Test plan
- Reset, then WRITE with ALUResultHI=32'h12345678, ALUResult=32'h9ABCDEF0 -> next cycle HI=32'h12345678, LO=32'h9ABCDEF0, Stall=0.
- DIVU RsData=100, RtData=7 ->
  - Busy high 32 cycles.
  - DivDone pulse after E32 with LO=14, HI=2.
  - An MTLO presented during Busy keeps Stall=1 and is accepted only after Busy falls.
- DIV RsData=-7 (32'hFFFFFFF9), RtData=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIV by zero, RsData=5, RtData=0 -> after 32 cycles LO=32'hFFFFFFFF, HI=5.
- DIV overflow, 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- MTHI 32'hAAAA0000, then DIVU 50/3, then assert Reset low at cycle 10 of the divide:
  - Immediately HI=0, LO=0, Busy=0, DivDone=0.
  - No late result write after reset release.

Source files
------------

// File: rtl/hi_lo_unit.sv
// hi_lo_unit: architectural HI/LO register pair plus a
// radix-2 restoring DIV/DIVU engine that stalls the pipe.
module hi_lo_unit #(
   parameter int DIV_STEPS = 32
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        OpValid,
   input  logic [2:0]  Op,
   input  logic [31:0] ALUResult,
   input  logic [31:0] ALUResultHI,
   input  logic [31:0] RsData,
   input  logic [31:0] RtData,
   input  logic        HiLoRead,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Busy,
   output logic        Stall,
   output logic        DivDone
);

   localparam int CW = $clog2(DIV_STEPS);
   localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);

   localparam logic [2:0] OP_WRITE = 3'b001;
   localparam logic [2:0] OP_MTHI  = 3'b010;
   localparam logic [2:0] OP_MTLO  = 3'b011;
   localparam logic [2:0] OP_DIV   = 3'b100;
   localparam logic [2:0] OP_DIVU  = 3'b101;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic [31:0]   rem_q, rem_d;
   logic [31:0]   quo_q, quo_d;
   logic [31:0]   dvs_q, dvs_d;
   logic [31:0]   dvd_q, dvd_d;
   logic          negq_q, negq_d;
   logic          negr_q, negr_d;
   logic          dvz_q, dvz_d;
   logic          done_q, done_d;

   logic          accept;
   logic          is_div;
   logic          a_neg, b_neg;
   logic [31:0]   a_mag, b_mag;
   logic [32:0]   rem33, diff;
   logic          step_ok;
   logic [31:0]   rem_nx, quo_nx;
   logic [31:0]   q_fix, r_fix;

   assign accept = OpValid & (state_q == S_IDLE);
   assign Busy   = (state_q == S_RUN);
   assign Stall  = Busy & (OpValid | HiLoRead);
   assign HI     = hi_q;
   assign LO     = lo_q;
   assign DivDone = done_q;

   // Operand magnitudes and the single restoring step datapath
   always_comb begin
      is_div  = (Op == OP_DIV);
      a_neg   = is_div & RsData[31];
      b_neg   = is_div & RtData[31];
      a_mag   = a_neg ? (32'd0 - RsData) : RsData;
      b_mag   = b_neg ? (32'd0 - RtData) : RtData;
      rem33   = {rem_q, quo_q[31]};
      diff    = rem33 - {1'b0, dvs_q};
      step_ok = ~diff[32];
      rem_nx  = step_ok ? diff[31:0] : rem33[31:0];
      quo_nx  = {quo_q[30:0], step_ok};
      q_fix   = negq_q ? (32'd0 - quo_nx) : quo_nx;
      r_fix   = negr_q ? (32'd0 - rem_nx) : rem_nx;
   end

   // Next state for HI/LO, op acceptance and the divider FSM
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      dvd_d   = dvd_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dvz_d   = dvz_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (Op)
                  OP_WRITE: begin
                     hi_d = ALUResultHI;
                     lo_d = ALUResult;
                  end
                  OP_MTHI: hi_d = RsData;
                  OP_MTLO: lo_d = RsData;
                  OP_DIV, OP_DIVU: begin
                     state_d = S_RUN;
                     cnt_d   = '0;
                     rem_d   = '0;
                     quo_d   = a_mag;
                     dvs_d   = b_mag;
                     dvd_d   = RsData;
                     negq_d  = a_neg ^ b_neg;
                     negr_d  = a_neg;
                     dvz_d   = (RtData == 32'd0);
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               if (dvz_q) begin
                  lo_d = 32'hFFFF_FFFF;
                  hi_d = dvd_q;
               end else begin
                  lo_d = q_fix;
                  hi_d = r_fix;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any divide in flight
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         dvd_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dvz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         dvd_q   <= dvd_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dvz_q   <= dvz_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_hi_lo_unit.sv
// tb_hi_lo_unit: directed self-checking bench for the
// HI/LO register pair and iterative divider.
module tb_hi_lo_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        OpValid;
   logic [2:0]  Op;
   logic [31:0] ALUResult;
   logic [31:0] ALUResultHI;
   logic [31:0] RsData;
   logic [31:0] RtData;
   logic        HiLoRead;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        Busy;
   logic        Stall;
   logic        DivDone;

   int checks = 0;
   int errors = 0;

   hi_lo_unit #(.DIV_STEPS(32)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .OpValid     (OpValid),
      .Op          (Op),
      .ALUResult   (ALUResult),
      .ALUResultHI (ALUResultHI),
      .RsData      (RsData),
      .RtData      (RtData),
      .HiLoRead    (HiLoRead),
      .HI          (HI),
      .LO          (LO),
      .Busy        (Busy),
      .Stall       (Stall),
      .DivDone     (DivDone)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic present(input logic [2:0] op,
                          input logic [31:0] rs,
                          input logic [31:0] rt);
      OpValid = 1'b1;
      Op      = op;
      RsData  = rs;
      RtData  = rt;
   endtask

   task automatic idle_in();
      OpValid = 1'b0;
      Op      = 3'b000;
   endtask

   task automatic run_div(input string tag,
                          input logic [2:0] op,
                          input logic [31:0] rs,
                          input logic [31:0] rt,
                          input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi);
      int n;
      present(op, rs, rt);
      step();
      idle_in();
      n = 0;
      while (!DivDone && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'd32);
      chk({tag, "_lo"}, LO, exp_lo);
      chk({tag, "_hi"}, HI, exp_hi);
      chk({tag, "_busy"}, 32'(Busy), 32'd0);
      step();
      chk({tag, "_done_clr"}, 32'(DivDone), 32'd0);
   endtask

   initial begin
      int n;
      int late;
      Reset       = 1'b0;
      OpValid     = 1'b0;
      Op          = 3'b000;
      ALUResult   = '0;
      ALUResultHI = '0;
      RsData      = '0;
      RtData      = '0;
      HiLoRead    = 1'b0;
      step();
      step();
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(DivDone), 32'd0);
      Reset = 1'b1;
      step();

      // WRITE
      ALUResultHI = 32'h1234_5678;
      ALUResult   = 32'h9ABC_DEF0;
      present(3'b001, 32'd0, 32'd0);
      #1;
      chk("wr_stall", 32'(Stall), 32'd0);
      step();
      idle_in();
      chk("wr_hi", HI, 32'h1234_5678);
      chk("wr_lo", LO, 32'h9ABC_DEF0);

      // OpValid=0 and unused opcode leave state alone
      ALUResultHI = 32'h0;
      ALUResult   = 32'h0;
      OpValid = 1'b0;
      Op      = 3'b001;
      step();
      chk("nov_hi", HI, 32'h1234_5678);
      present(3'b110, 32'h1111_1111, 32'd0);
      step();
      idle_in();
      chk("op6_hi", HI, 32'h1234_5678);
      chk("op6_lo", LO, 32'h9ABC_DEF0);

      // DIVU 100/7 with stall and held MTLO
      present(3'b101, 32'd100, 32'd7);
      step();
      idle_in();
      chk("divu_busy0", 32'(Busy), 32'd1);
      chk("divu_hold_lo", LO, 32'h9ABC_DEF0);
      n = 0;
      while (Busy && n < 40) begin
         if (n == 2) begin
            HiLoRead = 1'b1;
            #1;
            chk("rd_stall", 32'(Stall), 32'd1);
            HiLoRead = 1'b0;
            #1;
            chk("nord_stall", 32'(Stall), 32'd0);
         end
         if (n == 5) begin
            present(3'b011, 32'h0000_0055, 32'd0);
            #1;
            chk("mtlo_stall", 32'(Stall), 32'd1);
         end
         step();
         n++;
      end
      chk("divu_busy_cyc", 32'(n), 32'd32);
      chk("divu_done", 32'(DivDone), 32'd1);
      chk("divu_lo", LO, 32'd14);
      chk("divu_hi", HI, 32'd2);
      chk("mtlo_nostall", 32'(Stall), 32'd0);
      step();
      idle_in();
      chk("mtlo_lo", LO, 32'h0000_0055);
      chk("mtlo_hi", HI, 32'd2);
      chk("mtlo_done_clr", 32'(DivDone), 32'd0);

      // signed cases, divide by zero, overflow
      run_div("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_div("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE,
              32'hFFFF_FFFD, 32'd1);
      run_div("div_z", 3'b100, 32'd5, 32'd0,
              32'hFFFF_FFFF, 32'd5);
      run_div("divu_z", 3'b101, 32'hFFFF_FFF9, 32'd0,
              32'hFFFF_FFFF, 32'hFFFF_FFF9);
      run_div("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h8000_0000, 32'd0);
      run_div("divu_big", 3'b101, 32'hFFFF_FFF9, 32'd2,
              32'h7FFF_FFFC, 32'd1);

      // reset in the middle of a divide
      present(3'b010, 32'hAAAA_0000, 32'd0);
      step();
      idle_in();
      chk("mthi_hi", HI, 32'hAAAA_0000);
      present(3'b101, 32'd50, 32'd3);
      step();
      idle_in();
      repeat (10) step();
      chk("mid_busy", 32'(Busy), 32'd1);
      Reset = 1'b0;
      #1;
      chk("arst_hi", HI, 32'd0);
      chk("arst_lo", LO, 32'd0);
      chk("arst_busy", 32'(Busy), 32'd0);
      chk("arst_done", 32'(DivDone), 32'd0);
      step();
      Reset = 1'b1;
      late = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (DivDone || HI != 32'd0 || LO != 32'd0)
            late++;
      end
      chk("no_late_wr", 32'(late), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
